// File: rtl/src_control_sequencer_if.sv
// Strobe and handshake bundle between the Mini SRC control sequencer and the
// datapath/memory side. The sequencer owns the master modport.
interface src_control_sequencer_if #(
    parameter int unsigned OPW = 5
) ();

    // Instruction register contents and memory completion handshake
    logic [31:0]    IR;
    logic           mem_ready;

    // Register select/encode strobes
    logic           Gra;
    logic           Grb;
    logic           Grc;
    logic           Rin;
    logic           Rout;
    logic           BAout;

    // Datapath strobes
    logic           Cout;
    logic           PCout;
    logic           IncPC;
    logic           MARin;
    logic           MDRin;
    logic           MDRout;
    logic           IRin;
    logic           Yin;
    logic           Zin;
    logic           Zlowout;

    // Memory request strobes
    logic           Read;
    logic           Write;

    // ALU select and status
    logic [OPW-1:0] alu_op;
    logic           run;
    logic [3:0]     step;

    modport master (
        input  IR, mem_ready,
        output Gra, Grb, Grc, Rin, Rout, BAout,
        output Cout, PCout, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout,
        output Read, Write, alu_op, run, step
    );

    modport slave (
        output IR, mem_ready,
        input  Gra, Grb, Grc, Rin, Rout, BAout,
        input  Cout, PCout, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout,
        input  Read, Write, alu_op, run, step
    );

endinterface

// File: rtl/src_control_sequencer.sv
// Moore control-step sequencer for the Mini SRC datapath. Walks fetch
// (T0-T2) and an instruction-dependent execute tail (T3-T7), stalling in the
// memory steps until mem_ready is seen on a rising edge.
module src_control_sequencer #(
    parameter int unsigned    OPW      = 5,
    parameter logic [OPW-1:0] ADD_CODE = OPW'(5'b00011)
) (
    input logic                     clock,
    input logic                     clear,
    src_control_sequencer_if.master bus
);

    // Encodings double as the debug step value
    typedef enum logic [3:0] {
        StRst  = 4'd0,
        StT0   = 4'd1,
        StT1   = 4'd2,
        StT2   = 4'd3,
        StT3   = 4'd4,
        StT4   = 4'd5,
        StT5   = 4'd6,
        StT6   = 4'd7,
        StT7   = 4'd8,
        StHalt = 4'd15
    } state_e;

    localparam logic [OPW-1:0] OP_LD     = OPW'(5'b00000);
    localparam logic [OPW-1:0] OP_LDI    = OPW'(5'b00001);
    localparam logic [OPW-1:0] OP_ST     = OPW'(5'b00010);
    localparam logic [OPW-1:0] OP_RFIRST = OPW'(5'b00011);
    localparam logic [OPW-1:0] OP_RLAST  = OPW'(5'b01011);
    localparam logic [OPW-1:0] OP_ADDI   = OPW'(5'b01100);
    localparam logic [OPW-1:0] OP_ANDI   = OPW'(5'b01101);
    localparam logic [OPW-1:0] OP_ORI    = OPW'(5'b01110);
    localparam logic [OPW-1:0] OP_HALT   = OPW'(5'b11011);

    localparam logic [OPW-1:0] ALU_AND   = OPW'(5'b00101);
    localparam logic [OPW-1:0] ALU_OR    = OPW'(5'b00110);

    state_e state_q, state_d;

    logic [OPW-1:0] opcode;
    logic           is_ld;
    logic           is_ldi;
    logic           is_st;
    logic           is_rfmt;
    logic           is_imm;
    logic           is_halt;
    logic           is_exec;
    logic [OPW-1:0] imm_alu;

    assign opcode = bus.IR[31 -: OPW];

    // Opcode classification; only meaningful from T3 on, once IR holds the new word
    always_comb begin
        is_ld   = (opcode == OP_LD);
        is_ldi  = (opcode == OP_LDI);
        is_st   = (opcode == OP_ST);
        is_rfmt = (opcode >= OP_RFIRST) && (opcode <= OP_RLAST);
        is_imm  = (opcode == OP_ADDI) || (opcode == OP_ANDI) || (opcode == OP_ORI);
        is_halt = (opcode == OP_HALT);
        is_exec = is_ld || is_ldi || is_st || is_rfmt || is_imm;
        imm_alu = ADD_CODE;
        if (opcode == OP_ANDI) begin
            imm_alu = ALU_AND;
        end else if (opcode == OP_ORI) begin
            imm_alu = ALU_OR;
        end
    end

    // Next control step; mem_ready only matters in the three memory wait steps
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRst:  state_d = StT0;
            StT0:   state_d = StT1;
            StT1: begin
                if (bus.mem_ready) begin
                    state_d = StT2;
                end
            end
            StT2:   state_d = StT3;
            StT3: begin
                if (is_halt) begin
                    state_d = StHalt;
                end else if (is_exec) begin
                    state_d = StT4;
                end else begin
                    state_d = StT0;
                end
            end
            StT4:   state_d = StT5;
            StT5:   state_d = (is_ld || is_st) ? StT6 : StT0;
            StT6: begin
                if (!is_ld || bus.mem_ready) begin
                    state_d = StT7;
                end
            end
            StT7: begin
                if (!is_st || bus.mem_ready) begin
                    state_d = StT0;
                end
            end
            StHalt: state_d = StHalt;
            default: state_d = StRst;
        endcase
    end

    // Step register; clear forces RST immediately so every strobe drops at once
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q <= StRst;
        end else begin
            state_q <= state_d;
        end
    end

    // Strobe decode from the step register and IR. T3 decode needs the IR loaded
    // on the T2 edge, so the strobes cannot be precomputed into flops a cycle early.
    always_comb begin
        bus.Gra     = 1'b0;
        bus.Grb     = 1'b0;
        bus.Grc     = 1'b0;
        bus.Rin     = 1'b0;
        bus.Rout    = 1'b0;
        bus.BAout   = 1'b0;
        bus.Cout    = 1'b0;
        bus.PCout   = 1'b0;
        bus.IncPC   = 1'b0;
        bus.MARin   = 1'b0;
        bus.MDRin   = 1'b0;
        bus.MDRout  = 1'b0;
        bus.IRin    = 1'b0;
        bus.Yin     = 1'b0;
        bus.Zin     = 1'b0;
        bus.Zlowout = 1'b0;
        bus.Read    = 1'b0;
        bus.Write   = 1'b0;
        bus.alu_op  = '0;
        bus.run     = 1'b0;
        bus.step    = state_q;

        unique case (state_q)
            StT0: begin
                bus.run   = 1'b1;
                bus.PCout = 1'b1;
                bus.MARin = 1'b1;
                bus.IncPC = 1'b1;
            end
            StT1: begin
                bus.run   = 1'b1;
                bus.Read  = 1'b1;
                bus.MDRin = 1'b1;
            end
            StT2: begin
                bus.run    = 1'b1;
                bus.MDRout = 1'b1;
                bus.IRin   = 1'b1;
            end
            StT3: begin
                bus.run = 1'b1;
                if (is_rfmt || is_imm) begin
                    bus.Grb  = 1'b1;
                    bus.Rout = 1'b1;
                    bus.Yin  = 1'b1;
                end else if (is_ld || is_ldi || is_st) begin
                    bus.Grb   = 1'b1;
                    bus.BAout = 1'b1;
                    bus.Yin   = 1'b1;
                end
            end
            StT4: begin
                bus.run = 1'b1;
                bus.Zin = 1'b1;
                if (is_rfmt) begin
                    bus.Grc    = 1'b1;
                    bus.Rout   = 1'b1;
                    bus.alu_op = opcode;
                end else if (is_imm) begin
                    bus.Cout   = 1'b1;
                    bus.alu_op = imm_alu;
                end else begin
                    bus.Cout   = 1'b1;
                    bus.alu_op = ADD_CODE;
                end
            end
            StT5: begin
                bus.run     = 1'b1;
                bus.Zlowout = 1'b1;
                if (is_ld || is_st) begin
                    bus.MARin = 1'b1;
                end else begin
                    bus.Gra = 1'b1;
                    bus.Rin = 1'b1;
                end
            end
            StT6: begin
                bus.run   = 1'b1;
                bus.MDRin = 1'b1;
                if (is_st) begin
                    bus.Gra  = 1'b1;
                    bus.Rout = 1'b1;
                end else begin
                    bus.Read = 1'b1;
                end
            end
            StT7: begin
                bus.run = 1'b1;
                if (is_st) begin
                    bus.Write = 1'b1;
                end else begin
                    bus.MDRout = 1'b1;
                    bus.Gra    = 1'b1;
                    bus.Rin    = 1'b1;
                end
            end
            default: begin
                bus.run = 1'b0;
            end
        endcase
    end

    // Structural invariants of the decode
    a_gr_onehot: assert property (@(posedge clock) disable iff (clear)
        $onehot0({bus.Gra, bus.Grb, bus.Grc}));
    a_rin_rout: assert property (@(posedge clock) disable iff (clear)
        !(bus.Rin && bus.Rout));
    a_read_write: assert property (@(posedge clock) disable iff (clear)
        !(bus.Read && bus.Write));

endmodule

// File: tb/tb_src_control_sequencer.sv
// Bench for src_control_sequencer: each scenario pushes the per-cycle expected
// step/strobe vectors (with the IR and mem_ready to apply) into a scoreboard,
// then the queue is drained one clock at a time and compared at the negedge.
module tb_src_control_sequencer;

    logic clock = 1'b0;
    logic clear;

    src_control_sequencer_if #(.OPW(5)) bus ();

    src_control_sequencer #(
        .OPW      (5),
        .ADD_CODE (5'b00011)
    ) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Strobe bit positions inside the packed observation
    localparam logic [17:0] B_GRA   = 18'b1 << 17;
    localparam logic [17:0] B_GRB   = 18'b1 << 16;
    localparam logic [17:0] B_GRC   = 18'b1 << 15;
    localparam logic [17:0] B_RIN   = 18'b1 << 14;
    localparam logic [17:0] B_ROUT  = 18'b1 << 13;
    localparam logic [17:0] B_BAOUT = 18'b1 << 12;
    localparam logic [17:0] B_COUT  = 18'b1 << 11;
    localparam logic [17:0] B_PCOUT = 18'b1 << 10;
    localparam logic [17:0] B_INCPC = 18'b1 << 9;
    localparam logic [17:0] B_MARIN = 18'b1 << 8;
    localparam logic [17:0] B_MDRIN = 18'b1 << 7;
    localparam logic [17:0] B_MDROUT = 18'b1 << 6;
    localparam logic [17:0] B_IRIN  = 18'b1 << 5;
    localparam logic [17:0] B_YIN   = 18'b1 << 4;
    localparam logic [17:0] B_ZIN   = 18'b1 << 3;
    localparam logic [17:0] B_ZLOW  = 18'b1 << 2;
    localparam logic [17:0] B_READ  = 18'b1 << 1;
    localparam logic [17:0] B_WRITE = 18'b1;

    localparam logic [31:0] IR_ADD  = 32'h1918_0000;
    localparam logic [4:0]  OP_LD   = 5'b00000;
    localparam logic [4:0]  OP_LDI  = 5'b00001;
    localparam logic [4:0]  OP_ST   = 5'b00010;
    localparam logic [4:0]  OP_SUB  = 5'b00100;
    localparam logic [4:0]  OP_ADDI = 5'b01100;
    localparam logic [4:0]  OP_ANDI = 5'b01101;
    localparam logic [4:0]  OP_ORI  = 5'b01110;
    localparam logic [4:0]  OP_NOP  = 5'b11010;
    localparam logic [4:0]  OP_HALT = 5'b11011;
    localparam logic [4:0]  OP_BAD  = 5'b11111;

    typedef struct packed {
        logic [31:0] ir;
        logic        mr;
        logic [3:0]  step;
        logic        run;
        logic [4:0]  alu;
        logic [17:0] strb;
    } ent_t;

    ent_t sb[$];
    int   checks = 0;
    int   errors = 0;

    logic [17:0] obs_strb;
    assign obs_strb = {bus.Gra, bus.Grb, bus.Grc, bus.Rin, bus.Rout, bus.BAout, bus.Cout,
                       bus.PCout, bus.IncPC, bus.MARin, bus.MDRin, bus.MDRout, bus.IRin,
                       bus.Yin, bus.Zin, bus.Zlowout, bus.Read, bus.Write};

    function automatic logic [31:0] mk_ir(input logic [4:0] op);
        return {op, 27'h0ab_cdef};
    endfunction

    task automatic push(input logic [31:0] ir, input logic mr, input logic [3:0] step,
                        input logic run, input logic [4:0] alu, input logic [17:0] strb);
        ent_t e;
        e.ir = ir; e.mr = mr; e.step = step; e.run = run; e.alu = alu; e.strb = strb;
        sb.push_back(e);
    endtask

    // Fetch: T0, T1 held for 'waits' not-ready cycles, T2
    task automatic push_fetch(input logic [31:0] ir, input int waits);
        push(ir, 1'b1, 4'd1, 1'b1, 5'd0, B_PCOUT | B_MARIN | B_INCPC);
        for (int i = 0; i < waits; i++) push(ir, 1'b0, 4'd2, 1'b1, 5'd0, B_READ | B_MDRIN);
        push(ir, 1'b1, 4'd2, 1'b1, 5'd0, B_READ | B_MDRIN);
        push(ir, 1'b1, 4'd3, 1'b1, 5'd0, B_MDROUT | B_IRIN);
    endtask

    task automatic push_alu(input logic [31:0] ir, input logic imm, input logic [4:0] alu);
        push(ir, 1'b1, 4'd4, 1'b1, 5'd0, B_GRB | B_ROUT | B_YIN);
        if (imm) push(ir, 1'b1, 4'd5, 1'b1, alu, B_COUT | B_ZIN);
        else     push(ir, 1'b1, 4'd5, 1'b1, alu, B_GRC | B_ROUT | B_ZIN);
        push(ir, 1'b1, 4'd6, 1'b1, 5'd0, B_ZLOW | B_GRA | B_RIN);
    endtask

    task automatic push_addr(input logic [31:0] ir);
        push(ir, 1'b1, 4'd4, 1'b1, 5'd0, B_GRB | B_BAOUT | B_YIN);
        push(ir, 1'b1, 4'd5, 1'b1, 5'b00011, B_COUT | B_ZIN);
    endtask

    task automatic push_ld(input logic [31:0] ir, input int waits);
        push_addr(ir);
        push(ir, 1'b1, 4'd6, 1'b1, 5'd0, B_ZLOW | B_MARIN);
        for (int i = 0; i < waits; i++) push(ir, 1'b0, 4'd7, 1'b1, 5'd0, B_READ | B_MDRIN);
        push(ir, 1'b1, 4'd7, 1'b1, 5'd0, B_READ | B_MDRIN);
        push(ir, 1'b0, 4'd8, 1'b1, 5'd0, B_MDROUT | B_GRA | B_RIN);
    endtask

    task automatic push_st(input logic [31:0] ir, input int waits);
        push_addr(ir);
        push(ir, 1'b1, 4'd6, 1'b1, 5'd0, B_ZLOW | B_MARIN);
        push(ir, 1'b0, 4'd7, 1'b1, 5'd0, B_GRA | B_ROUT | B_MDRIN);
        for (int i = 0; i < waits; i++) push(ir, 1'b0, 4'd8, 1'b1, 5'd0, B_WRITE);
        push(ir, 1'b1, 4'd8, 1'b1, 5'd0, B_WRITE);
    endtask

    // Called at posedge+1; leaves at posedge+1 after the last queued cycle
    task automatic run_queue(input string tag);
        ent_t e;
        int   cyc = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            bus.IR = e.ir;
            bus.mem_ready = e.mr;
            @(negedge clock);
            checks++;
            if ({bus.step, bus.run, bus.alu_op, obs_strb} !== {e.step, e.run, e.alu, e.strb}) begin
                errors++;
                $display("FAIL %s cycle %0d: got step=%0d run=%b alu=%b strb=%b, expected step=%0d run=%b alu=%b strb=%b",
                         tag, cyc, bus.step, bus.run, bus.alu_op, obs_strb,
                         e.step, e.run, e.alu, e.strb);
            end
            @(posedge clock);
            #1;
            cyc++;
        end
    endtask

    task automatic check_idle(input string tag);
        checks++;
        if ({bus.step, bus.run, bus.alu_op, obs_strb} !== 28'd0) begin
            errors++;
            $display("FAIL %s: got step=%0d run=%b alu=%b strb=%b, expected all zero",
                     tag, bus.step, bus.run, bus.alu_op, obs_strb);
        end
    endtask

    // Pulse clear from posedge+1 and come back at posedge+1 with T0 present
    task automatic do_clear(input string tag);
        clear = 1'b1;
        #1;
        check_idle(tag);
        @(posedge clock);
        #1;
        clear = 1'b0;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        clear = 1'b1;
        bus.IR = IR_ADD;
        bus.mem_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_idle("reset_idle");
        bus.mem_ready = 1'b1;
        @(negedge clock);
        check_idle("reset_ignores_ready");
        @(posedge clock);
        #1;
        clear = 1'b0;
        @(posedge clock);
        #1;
    endtask

    task automatic test_add();
        push_fetch(IR_ADD, 0);
        push_alu(IR_ADD, 1'b0, 5'b00011);
        run_queue("add");
    endtask

    task automatic test_ld_wait();
        push_fetch(mk_ir(OP_LD), 3);
        push_ld(mk_ir(OP_LD), 3);
        run_queue("ld_wait");
    endtask

    task automatic test_st();
        push_fetch(mk_ir(OP_ST), 0);
        push_st(mk_ir(OP_ST), 0);
        push_fetch(mk_ir(OP_ST), 1);
        push_st(mk_ir(OP_ST), 2);
        run_queue("st");
    endtask

    task automatic test_imm();
        push_fetch(mk_ir(OP_ANDI), 0);
        push_alu(mk_ir(OP_ANDI), 1'b1, 5'b00101);
        push_fetch(mk_ir(OP_ORI), 0);
        push_alu(mk_ir(OP_ORI), 1'b1, 5'b00110);
        push_fetch(mk_ir(OP_ADDI), 0);
        push_alu(mk_ir(OP_ADDI), 1'b1, 5'b00011);
        run_queue("imm");
    endtask

    task automatic test_nop_unknown();
        push_fetch(mk_ir(OP_BAD), 0);
        push(mk_ir(OP_BAD), 1'b1, 4'd4, 1'b1, 5'd0, 18'd0);
        push_fetch(mk_ir(OP_NOP), 0);
        push(mk_ir(OP_NOP), 1'b1, 4'd4, 1'b1, 5'd0, 18'd0);
        run_queue("nop_unknown");
    endtask

    task automatic test_back_to_back();
        push_fetch(mk_ir(OP_SUB), 0);
        push_alu(mk_ir(OP_SUB), 1'b0, OP_SUB);
        push_fetch(mk_ir(OP_LDI), 2);
        push_addr(mk_ir(OP_LDI));
        push(mk_ir(OP_LDI), 1'b0, 4'd6, 1'b1, 5'd0, B_ZLOW | B_GRA | B_RIN);
        push_fetch(mk_ir(OP_LD), 0);
        push_ld(mk_ir(OP_LD), 0);
        run_queue("back_to_back");
    endtask

    task automatic test_halt();
        push_fetch(mk_ir(OP_HALT), 0);
        push(mk_ir(OP_HALT), 1'b1, 4'd4, 1'b1, 5'd0, 18'd0);
        for (int i = 0; i < 20; i++) push(mk_ir(OP_HALT), i[0], 4'd15, 1'b0, 5'd0, 18'd0);
        run_queue("halt");
        do_clear("halt_clear");
        push_fetch(IR_ADD, 0);
        push_alu(IR_ADD, 1'b0, 5'b00011);
        run_queue("halt_restart");
    endtask

    task automatic test_clear_mid_fetch();
        push(IR_ADD, 1'b1, 4'd1, 1'b1, 5'd0, B_PCOUT | B_MARIN | B_INCPC);
        push(IR_ADD, 1'b0, 4'd2, 1'b1, 5'd0, B_READ | B_MDRIN);
        push(IR_ADD, 1'b0, 4'd2, 1'b1, 5'd0, B_READ | B_MDRIN);
        run_queue("pre_clear");
        checks++;
        if (bus.Read !== 1'b1) begin
            errors++;
            $display("FAIL read_before_clear: got Read=%b, expected 1", bus.Read);
        end
        do_clear("clear_in_t1");
        push_fetch(mk_ir(OP_NOP), 1);
        push(mk_ir(OP_NOP), 1'b1, 4'd4, 1'b1, 5'd0, 18'd0);
        push(mk_ir(OP_NOP), 1'b1, 4'd1, 1'b1, 5'd0, B_PCOUT | B_MARIN | B_INCPC);
        run_queue("post_clear");
    endtask

    initial begin
        test_reset();
        test_add();
        test_ld_wait();
        test_st();
        test_imm();
        test_nop_unknown();
        test_back_to_back();
        test_halt();
        test_clear_mid_fetch();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
